// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer (master) and the RISC datapath (slave).
// Carries the decoded IR/CON/stop inputs and every datapath strobe.
interface control_sequencer_if #(
    parameter int IR_W = 32,
    parameter int OP_W = 5
);
    logic [IR_W-1:0] ir;
    logic            CON;
    logic            stop;

    logic PCout, IncPC, PCin, MARin, memRead, MDRin, MDRout, ramEnable, IRin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, R15in;
    logic Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin;
    logic InPort_Out, OutPort_In;
    logic [OP_W-1:0] alu_op;
    logic run;
    logic illegal_op;

    modport master (
        input  ir, CON, stop,
        output PCout, IncPC, PCin, MARin, memRead, MDRin, MDRout, ramEnable, IRin,
        output Gra, Grb, Grc, Rin, Rout, BAout, R15in,
        output Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin,
        output InPort_Out, OutPort_In, alu_op, run, illegal_op
    );

    modport slave (
        output ir, CON, stop,
        input  PCout, IncPC, PCin, MARin, memRead, MDRin, MDRout, ramEnable, IRin,
        input  Gra, Grb, Grc, Rin, Rout, BAout, R15in,
        input  Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin,
        input  InPort_Out, OutPort_In, alu_op, run, illegal_op
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the 32-bit RISC datapath (steps T0..T7).
// Optional ILLEGAL_TRAP_EN: opcodes 28-31 halt and raise a sticky illegal_op.
module control_sequencer #(
    parameter int              IR_W     = 32,
    parameter int              OP_W     = 5,
    parameter logic [OP_W-1:0] ADD_CODE = OP_W'(3)
) (
    input logic                 clock,
    input logic                 clear,
    control_sequencer_if.master bus
);
    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [OP_W-1:0] OP_LD     = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDI    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ST     = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ALU_LO = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ALU_HI = OP_W'(11);
    localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ANDI   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_ORI    = OP_W'(14);
    localparam logic [OP_W-1:0] OP_DIV    = OP_W'(15);
    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(16);
    localparam logic [OP_W-1:0] OP_NEG    = OP_W'(17);
    localparam logic [OP_W-1:0] OP_NOT    = OP_W'(18);
    localparam logic [OP_W-1:0] OP_BR     = OP_W'(19);
    localparam logic [OP_W-1:0] OP_JR     = OP_W'(20);
    localparam logic [OP_W-1:0] OP_JAL    = OP_W'(21);
    localparam logic [OP_W-1:0] OP_IN     = OP_W'(22);
    localparam logic [OP_W-1:0] OP_OUT    = OP_W'(23);
    localparam logic [OP_W-1:0] OP_MFHI   = OP_W'(24);
    localparam logic [OP_W-1:0] OP_MFLO   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_NOP    = OP_W'(26);
    localparam logic [OP_W-1:0] OP_HALT   = OP_W'(27);

    localparam logic [OP_W-1:0] ALU_AND = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_OR  = OP_W'(6);

    typedef struct packed {
        logic pc_out, inc_pc, pc_in, mar_in, mem_read, mdr_in, mdr_out, ram_en, ir_in;
        logic gra, grb, grc, rin, rout, ba_out, r15_in;
        logic yin, zin, zhigh_out, zlow_out, hi_in, lo_in, hi_out, lo_out, c_out, con_in;
        logic inport_out, outport_in;
    } strobe_t;

    logic [3:0]      state, state_nxt;
    logic [OP_W-1:0] op;
    logic [2:0]      step;
    strobe_t         st;
    logic [OP_W-1:0] alu_sel;
    logic            done;
    logic            to_halt;
    logic            imm;
`ifdef ILLEGAL_TRAP_EN
    logic            ill_hit;
    logic            ill_q;
`endif

    assign op   = bus.ir[IR_W-1 -: OP_W];
    assign step = 3'(state - S_T3);
    assign imm  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);

    always_comb begin
        st      = '0;
        alu_sel = '0;
        done    = 1'b0;
        to_halt = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        ill_hit = 1'b0;
`endif
        case (state)
            S_T0: begin st.pc_out = 1'b1; st.mar_in = 1'b1; st.inc_pc = 1'b1; end
            S_T1: begin st.mem_read = 1'b1; st.mdr_in = 1'b1; end
            S_T2: begin st.mdr_out = 1'b1; st.ir_in = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (op) inside
                    [OP_ALU_LO:OP_ALU_HI], OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (step)
                            3'd0: begin st.grb = 1'b1; st.rout = 1'b1; st.yin = 1'b1; end
                            3'd1: begin
                                st.zin = 1'b1;
                                if (imm) begin
                                    st.c_out = 1'b1;
                                    alu_sel  = (op == OP_ADDI) ? ADD_CODE :
                                               (op == OP_ANDI) ? ALU_AND : ALU_OR;
                                end else begin
                                    st.grc  = 1'b1;
                                    st.rout = 1'b1;
                                    alu_sel = op;
                                end
                            end
                            3'd2: begin st.zlow_out = 1'b1; st.gra = 1'b1; st.rin = 1'b1; done = 1'b1; end
                            default: ;
                        endcase
                    end
                    // ld/ldi/st share the base+offset address computation in T3-T4
                    OP_LD, OP_LDI, OP_ST: begin
                        case (step)
                            3'd0: begin st.grb = 1'b1; st.ba_out = 1'b1; st.yin = 1'b1; end
                            3'd1: begin st.c_out = 1'b1; st.zin = 1'b1; alu_sel = ADD_CODE; end
                            3'd2: begin
                                st.zlow_out = 1'b1;
                                if (op == OP_LDI) begin
                                    st.gra = 1'b1; st.rin = 1'b1; done = 1'b1;
                                end else begin
                                    st.mar_in = 1'b1;
                                end
                            end
                            3'd3: begin
                                st.mdr_in = 1'b1;
                                if (op == OP_LD) st.mem_read = 1'b1;
                                else begin st.gra = 1'b1; st.rout = 1'b1; end
                            end
                            3'd4: begin
                                if (op == OP_LD) begin st.mdr_out = 1'b1; st.gra = 1'b1; st.rin = 1'b1; end
                                else st.ram_en = 1'b1;
                                done = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_DIV, OP_MUL: begin
                        case (step)
                            3'd0: begin st.gra = 1'b1; st.rout = 1'b1; st.yin = 1'b1; end
                            3'd1: begin st.grb = 1'b1; st.rout = 1'b1; st.zin = 1'b1; alu_sel = op; end
                            3'd2: begin st.zlow_out = 1'b1; st.lo_in = 1'b1; end
                            3'd3: begin st.zhigh_out = 1'b1; st.hi_in = 1'b1; done = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (step)
                            3'd0: begin st.grb = 1'b1; st.rout = 1'b1; st.zin = 1'b1; alu_sel = op; end
                            3'd1: begin st.zlow_out = 1'b1; st.gra = 1'b1; st.rin = 1'b1; done = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (step)
                            3'd0: begin st.grb = 1'b1; st.rout = 1'b1; st.con_in = 1'b1; end
                            3'd1: begin st.pc_out = 1'b1; st.yin = 1'b1; end
                            3'd2: begin st.c_out = 1'b1; st.zin = 1'b1; alu_sel = ADD_CODE; end
                            3'd3: begin
                                // untaken branch still spends the T6 slot, just without strobes
                                st.zlow_out = bus.CON;
                                st.pc_in    = bus.CON;
                                done        = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_JAL: begin
                        case (step)
                            3'd0: begin st.pc_out = 1'b1; st.r15_in = 1'b1; end
                            3'd1: begin st.gra = 1'b1; st.rout = 1'b1; st.pc_in = 1'b1; done = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT: begin
                        if (step == 3'd0) begin
                            st.gra        = (op != OP_NOP) && (op != OP_HALT);
                            st.rout       = (op == OP_JR) || (op == OP_OUT);
                            st.rin        = (op == OP_IN) || (op == OP_MFHI) || (op == OP_MFLO);
                            st.pc_in      = (op == OP_JR);
                            st.inport_out = (op == OP_IN);
                            st.outport_in = (op == OP_OUT);
                            st.hi_out     = (op == OP_MFHI);
                            st.lo_out     = (op == OP_MFLO);
                            to_halt       = (op == OP_HALT);
                            done          = (op != OP_HALT);
                        end
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        to_halt = (step == 3'd0);
                        ill_hit = (step == 3'd0);
`else
                        done    = (step == 3'd0);
`endif
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST: state_nxt = S_T0;
            S_T0:  state_nxt = S_T1;
            S_T1:  state_nxt = S_T2;
            S_T2:  state_nxt = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (to_halt)   state_nxt = S_HALT;
                else if (done) state_nxt = bus.stop ? S_HALT : S_T0;
                else           state_nxt = state + 4'd1;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= S_RST;
        else        state <= state_nxt;
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)       ill_q <= 1'b0;
        else if (ill_hit) ill_q <= 1'b1;
    end
    assign bus.illegal_op = ill_q;
`else
    assign bus.illegal_op = 1'b0;
`endif

    assign bus.run        = (state >= S_T0) && (state <= S_T7);
    assign bus.alu_op     = alu_sel;
    assign bus.PCout      = st.pc_out;
    assign bus.IncPC      = st.inc_pc;
    assign bus.PCin       = st.pc_in;
    assign bus.MARin      = st.mar_in;
    assign bus.memRead    = st.mem_read;
    assign bus.MDRin      = st.mdr_in;
    assign bus.MDRout     = st.mdr_out;
    assign bus.ramEnable  = st.ram_en;
    assign bus.IRin       = st.ir_in;
    assign bus.Gra        = st.gra;
    assign bus.Grb        = st.grb;
    assign bus.Grc        = st.grc;
    assign bus.Rin        = st.rin;
    assign bus.Rout       = st.rout;
    assign bus.BAout      = st.ba_out;
    assign bus.R15in      = st.r15_in;
    assign bus.Yin        = st.yin;
    assign bus.Zin        = st.zin;
    assign bus.Zhighout   = st.zhigh_out;
    assign bus.Zlowout    = st.zlow_out;
    assign bus.HIin       = st.hi_in;
    assign bus.LOin       = st.lo_in;
    assign bus.HIout      = st.hi_out;
    assign bus.LOout      = st.lo_out;
    assign bus.Cout       = st.c_out;
    assign bus.CONin      = st.con_in;
    assign bus.InPort_Out = st.inport_out;
    assign bus.OutPort_In = st.outport_in;
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit RISC datapath. It replaces the hand-driven control signals now applied step by step in the phase benches.
- Steps each instruction through fetch (T0–T2) and execute (T3–T7), driving the existing datapath strobes directly.
- Decodes the opcode from IR[31:27] and samples the branch condition flop (CON).
- Stops on halt, on an external stop request, or (optionally) on an illegal opcode.

Parameters:
- IR_W, 32, instruction register width.
- OP_W, 5, opcode width; the opcode is always IR[IR_W-1 -: OP_W].
- ADD_CODE, 5'd3, alu_op value used for address and branch-target addition.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- ir  in  IR_W  current IR contents.
- CON  in  1  branch-condition flop output.
- stop  in  1  request to halt at the next instruction boundary.
- PCout, IncPC, PCin, MARin, memRead, MDRin, MDRout, ramEnable, IRin  out  1 each  fetch/memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, R15in  out  1 each  register-select strobes.
- Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin  out  1 each  ALU/HI/LO strobes.
- InPort_Out, OutPort_In  out  1 each  I/O strobes.
- alu_op  out  OP_W  ALU operation code, meaningful only while Zin=1.
- run  out  1  high while sequencing.
- illegal_op  out  1  sticky illegal-opcode flag (optional feature only).

Behaviour:
- **States:** RST, T0..T7, HALT.
  - clear low forces RST immediately (async): every output is 0, including run.
  - RST → T0 on the first rising edge after release.
- **Output timing:** outputs are a combinational decode of the registered state and ir. Each step lasts exactly 1 cycle. Outputs not listed for a step are 0.
- **Fetch:**
  - T0: PCout, MARin, IncPC.
  - T1: memRead, MDRin.
  - T2: MDRout, IRin.
  - The execute decode uses ir as loaded at the end of T2.
- **Execute sequences by opcode.** "Done" means the step is the last one of the instruction; the next state is T0.
  - 3–11 (ALU): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, alu_op=opcode; T5 Zlowout,Gra,Rin; done.
  - 12/13/14 (immediate): as ALU, but T4 uses Cout instead of Grc,Rout, with alu_op=3/5/6 respectively.
  - 1 ldi: T3 Grb,BAout,Yin; T4 Cout,Zin, alu_op=ADD_CODE; T5 Zlowout,Gra,Rin; done.
  - 0 ld: T3–T4 as ldi; T5 Zlowout,MARin; T6 memRead,MDRin; T7 MDRout,Gra,Rin; done.
  - 2 st: T3–T4 as ldi; T5 Zlowout,MARin; T6 Gra,Rout,MDRin; T7 ramEnable; done.
  - 15/16 (div/mul): T3 Gra,Rout,Yin; T4 Grb,Rout,Zin, alu_op=opcode; T5 Zlowout,LOin; T6 Zhighout,HIin; done.
  - 17/18 (neg/not): T3 Grb,Rout,Zin, alu_op=opcode; T4 Zlowout,Gra,Rin; done.
  - 19 br: T3 Grb,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin, alu_op=ADD_CODE; T6 Zlowout,PCin only if CON=1, otherwise no strobes; done.
  - 20 jr: T3 Gra,Rout,PCin; done.
  - 21 jal: T3 PCout,R15in; T4 Gra,Rout,PCin; done.
  - 22 in: T3 InPort_Out,Gra,Rin; done.
  - 23 out: T3 Gra,Rout,OutPort_In; done.
  - 24 mfhi: T3 HIout,Gra,Rin; done.
  - 25 mflo: T3 LOout,Gra,Rin; done.
  - 26 nop: T3 with no strobes; done.
  - 27 halt: T3 → HALT.
  - 28–31: see Optional Feature.
- **Stop:** stop is sampled only on the done-step edge. If stop=1 there, the next state is HALT instead of T0; the current instruction still completes.
- **HALT:** run=0 and all strobes are 0. HALT is left only via clear.
- **Mid-instruction reset:** strobes drop in the same instant as clear falls. No partial completion is guaranteed; the datapath is cleared by the same reset.
- **run:** 1 in T0..T7.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: opcodes 28–31 go T3 → HALT. illegal_op sets to 1 on entry to HALT and stays 1 until clear.
- Undefined: opcodes 28–31 behave as nop; the illegal_op port is still present and tied to 0.

Test Plan:
- ir=32'hAB000000 (jal): T0–T2 fetch strobes; T3 PCout=R15in=1; T4 Gra=Rout=PCin=1; T0 again at cycle 6.
- ir=32'h19000000 (add): T4 alu_op=3 with Zin=1; T5 Zlowout,Gra,Rin; instruction length 6 cycles.
- ir=32'h98000000 (br): with CON=0, T6 has all strobes 0. Repeated with CON=1, T6 has Zlowout=PCin=1.
- ir=32'h00000000 (ld): memRead=1 in T1 and T6; MDRout with Rin in T7; length 8 cycles. Assert clear low during T5: all outputs 0 immediately; after release, RST then T0.
- ir=32'hD8000000 (halt): run falls after T3 and stays 0 for 20 cycles. In a separate run, stop=1 during an add's T5: HALT follows with no T0.
- ir=32'hF8000000 (opcode 31): with ILLEGAL_TRAP_EN, HALT is entered and illegal_op=1. Without it, behaves as nop and returns to T0 after T3.
